// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parametrised UART receiver
// Purpose: FSM state enum, ceiling-log2 helper for counter widths, default baud divisor.
// Ports: none (package).
package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 56;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  // Smallest r with 2**r >= value; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser plus falling-edge detector for the rx line
// Purpose: bring the asynchronous serial line into the sclk domain and flag its falling edges.
// Ports:
//   sclk   in   system clock
//   s_rst  in   asynchronous reset, active-high; presets all flops to 1 (idle line)
//   i_rx   in   raw serial line
//   o_cur  out  synchronised line level
//   o_fall out  one-cycle pulse on a synchronised high-to-low transition
module uart_rx_sync (
  input  logic sclk,
  input  logic s_rst,
  input  logic i_rx,
  output logic o_cur,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Preset high so that reset release on an idle line never looks like a start edge.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_cur  = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority vote
// Purpose: receive LSB-first frames (start, DATA_W data, optional parity, STOP_BITS stop)
//   and present each word with a one-cycle po_flag strobe plus framing/parity status.
// Optional feature: define UART_RX_PARITY_EN to expect and check a parity bit after the data.
// Ports:
//   sclk        in   system clock
//   s_rst       in   asynchronous reset, active-high
//   rs232_rx    in   serial line, idle high, asynchronous to sclk
//   rx_data     out  last received word, held until the next po_flag
//   po_flag     out  one-cycle strobe: rx_data/frame_err/parity_err valid
//   frame_err   out  a stop bit was voted low
//   parity_err  out  parity mismatch (always 0 without UART_RX_PARITY_EN)
//   rx_busy     out  high from start-bit detect until frame end or false-start abort
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              rs232_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              po_flag,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_busy
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam int IDX_W = clog2(DATA_W + 1);
  localparam int MID   = CLK_DIV / 2;

  localparam logic [CNT_W-1:0] C_SMP0 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] C_SMP1 = CNT_W'(MID);
  localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic              w_cur;
  logic              w_fall;
  logic              w_vote;
  logic              w_dec;
  logic              w_end;
  logic              w_busy;
  logic              w_parity_err;
  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_smp0;
  logic              r_smp1;
  logic [DATA_W-1:0] r_shift;
  logic              r_ferr;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_po_flag;
  logic              r_frame_err;
  logic              r_parity_err;

  uart_rx_sync u_sync (
    .sclk   (sclk),
    .s_rst  (s_rst),
    .i_rx   (rs232_rx),
    .o_cur  (w_cur),
    .o_fall (w_fall)
  );

  // Third sample is the live line at the decision cycle, so no extra register is needed.
  assign w_vote = (r_smp0 & r_smp1) | (r_smp0 & w_cur) | (r_smp1 & w_cur);
  assign w_dec  = (r_cnt == C_DEC);
  assign w_end  = (r_cnt == C_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_pbit;
  assign w_parity_err = ((^r_shift) ^ r_pbit) != 1'(PARITY_ODD);
`else
  assign w_parity_err = 1'b0;
`endif

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) w_next = START;
      end
      START: begin
        w_busy = 1'b1;
        if (w_dec && w_vote) w_next = IDLE;  // false start: line back high by mid-bit
        else if (w_end)      w_next = DATA;
      end
      DATA: begin
        w_busy = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (w_end && (r_idx == DATA_LAST)) w_next = PARITY;
`else
        if (w_end && (r_idx == DATA_LAST)) w_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        w_busy = 1'b1;
        if (w_end) w_next = STOP;
      end
`endif
      STOP: begin
        w_busy = 1'b1;
        // Leave at mid-bit of the last stop bit so a following start edge is not missed.
        if (w_dec && (r_idx == STOP_LAST)) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_smp0       <= 1'b1;
      r_smp1       <= 1'b1;
      r_shift      <= '0;
      r_ferr       <= 1'b0;
      r_rx_data    <= '0;
      r_po_flag    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbit       <= 1'b0;
`endif
    end else begin
      r_po_flag <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt  <= '0;
        r_idx  <= '0;
        r_ferr <= 1'b0;
      end else if (r_state == DONE) begin
        r_rx_data    <= r_shift;
        r_po_flag    <= 1'b1;
        r_frame_err  <= r_ferr;
        r_parity_err <= w_parity_err;
      end else begin
        r_cnt <= w_end ? '0 : r_cnt + 1'b1;
        if (r_cnt == C_SMP0) r_smp0 <= w_cur;
        if (r_cnt == C_SMP1) r_smp1 <= w_cur;
        if (w_dec) begin
          if (r_state == DATA) r_shift <= {w_vote, r_shift[DATA_W-1:1]};
          if ((r_state == STOP) && !w_vote) r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_state == PARITY) r_pbit <= w_vote;
`endif
        end
        if (w_end) begin
          if (r_state == DATA) r_idx <= (r_idx == DATA_LAST) ? '0 : r_idx + 1'b1;
          if (r_state == STOP) r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign po_flag    = r_po_flag;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign rx_busy    = w_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param
module tb_uart_rx_param;

  localparam int CLK_DIV    = 56;
  localparam int DATA_W     = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + P + STOP_BITS;

  logic              sclk = 1'b0;
  logic              s_rst = 1'b1;
  logic              rs232_rx = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              po_flag;
  logic              frame_err;
  logic              parity_err;
  logic              rx_busy;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  logic [DATA_W+1:0] exp_q[$];
  longint            flag_t[$];
  logic [DATA_W+1:0] e;

  always #5 sclk = ~sclk;

  uart_rx_param #(
    .CLK_DIV    (CLK_DIV),
    .DATA_W     (DATA_W),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .rs232_rx   (rs232_rx),
    .rx_data    (rx_data),
    .po_flag    (po_flag),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge sclk) begin
    if (po_flag === 1'b1) begin
      flag_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_po_flag", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e[DATA_W+1:2]);
        check("frame_err", frame_err, e[1]);
        check("parity_err", parity_err, e[0]);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(negedge sclk);
  endtask

  // Drives one frame bit-serially. glitch_bit >= 0 inverts that data bit for one cycle
  // aligned to the receiver's middle sample; rst_bit >= 0 pulses reset inside that data bit.
  task automatic send(input logic [DATA_W-1:0] d, input logic stop_v, input logic pflip,
                      input int glitch_bit, input int rst_bit, input int gap);
    logic [FRAME_BITS-1:0] bits;
    logic pbit;
    logic perr;
    pbit = (^d) ^ 1'(PARITY_ODD) ^ pflip;
`ifdef UART_RX_PARITY_EN
    perr = ((^d) ^ pbit) != 1'(PARITY_ODD);
`else
    perr = 1'b0;
`endif
    bits = '0;
    for (int i = 0; i < DATA_W; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[1+DATA_W] = pbit;
`endif
    for (int s = 0; s < STOP_BITS; s++) bits[1+DATA_W+P+s] = stop_v;
    if (rst_bit < 0) exp_q.push_back({d, ~stop_v, perr});
    for (int b = 0; b < FRAME_BITS; b++) begin
      if (rst_bit >= 0 && b == rst_bit + 1) begin
        hold(bits[b], CLK_DIV / 3);
        s_rst = 1'b1;
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_po_flag", po_flag, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        @(negedge sclk);
        rs232_rx = 1'b1;
        s_rst = 1'b0;
        return;
      end else if (glitch_bit >= 0 && b == glitch_bit + 1) begin
        hold(bits[b], CLK_DIV / 2 + 1);
        hold(~bits[b], 1);
        hold(bits[b], CLK_DIV - CLK_DIV / 2 - 2);
      end else begin
        hold(bits[b], CLK_DIV);
      end
    end
    hold(1'b1, gap * CLK_DIV);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * FRAME_BITS * CLK_DIV) begin
      @(negedge sclk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit busy_seen;
    logic [DATA_W-1:0] d;
    logic sv;
    logic pf;
    int gb;
    int gap;

    repeat (3) @(negedge sclk);
    check("reset_rx_data", rx_data, 0);
    check("reset_po_flag", po_flag, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    s_rst = 1'b0;
    hold(1'b1, CLK_DIV);

    send(8'h55, 1'b1, 1'b0, -1, -1, 1);
    wait_drain();

    // False start: short low pulse must raise rx_busy but produce no strobe.
    n0 = flag_t.size();
    busy_seen = 0;
    rs232_rx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      if (rx_busy) busy_seen = 1;
    end
    rs232_rx = 1'b1;
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      @(negedge sclk);
      if (rx_busy) busy_seen = 1;
    end
    check("false_start_busy_seen", busy_seen, 1);
    check("false_start_busy_low", rx_busy, 0);
    check("false_start_no_flag", flag_t.size(), n0);
    send(8'hA3, 1'b1, 1'b0, -1, -1, 1);
    wait_drain();

    send(8'h3C, 1'b0, 1'b0, -1, -1, 2);
    wait_drain();

    // Back-to-back frames: strobes exactly one frame time apart.
    n0 = flag_t.size();
    send(8'h01, 1'b1, 1'b0, -1, -1, 0);
    send(8'hFE, 1'b1, 1'b0, -1, -1, 1);
    wait_drain();
    if (flag_t.size() >= n0 + 2)
      check("back_to_back_spacing", flag_t[n0+1] - flag_t[n0], FRAME_BITS * CLK_DIV);
    else
      check("back_to_back_count", flag_t.size() - n0, 2);

    send(8'h5A, 1'b1, 1'b0, 3, -1, 1);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, -1, -1, 1);
    send(8'h07, 1'b1, 1'b1, -1, -1, 1);
    wait_drain();
`endif

    // Reset mid-frame: no strobe for the aborted frame, next frame clean.
    n0 = flag_t.size();
    send(8'h96, 1'b1, 1'b0, -1, 4, 0);
    hold(1'b1, 2 * CLK_DIV);
    check("abort_no_flag", flag_t.size(), n0);
    send(8'h69, 1'b1, 1'b0, -1, -1, 1);
    wait_drain();

    // Break: exactly one all-zero frame with frame_err, then silence until a new edge.
    n0 = flag_t.size();
    exp_q.push_back({{DATA_W{1'b0}}, 1'b1, (P == 1) ? (1'(0) != 1'(PARITY_ODD)) : 1'b0});
    hold(1'b0, (FRAME_BITS + 3) * CLK_DIV);
    hold(1'b1, 2 * CLK_DIV);
    wait_drain();
    check("break_one_flag", flag_t.size() - n0, 1);

    for (int k = 0; k < 20; k++) begin
      d   = DATA_W'($urandom);
      sv  = ($urandom_range(0, 5) != 0);
      pf  = 1'($urandom_range(0, 1));
      gb  = int'($urandom_range(0, DATA_W)) - 1;
      gap = int'($urandom_range(0, 2));
      if (!sv && gap == 0) gap = 1;
      send(d, sv, pf, gb, -1, gap);
    end
    hold(1'b1, CLK_DIV);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
